// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle RISC-V controller.
// Holds the FSM state encoding, the opcodes the controller understands and
// the encodings of every datapath select it drives.
package mc_pkg;

  // Opcodes (instr[6:0]) handled by the controller
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // FSM states; encodings 12..15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  // alu_op
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // result_src
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // alu_src_a
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // alu_src_b
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // imm_src
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_imm_decode.sv
// Immediate-format decoder: maps the opcode straight to the imm_src select,
// independent of the FSM state so the extender is ready as soon as IR is.
// Ports:
//   op       in  7  instr[6:0]
//   imm_src  out 2  00 I, 01 S, 10 B, 11 J (I for anything unrecognised)
module mc_imm_decode
  import mc_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RISC-V core (lw, sw, R-type, I-type
// ALU, beq, jal). Sequences the shared ALU, the unified memory port and the
// IR/PC/register-file enables, stalling in FETCH/MEMREAD/MEMWRITE until the
// memory port reports completion.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   op[6:0], zero, mem_ready   opcode from IR, ALU zero flag, memory done
//   pc_write, ir_write,        enables (all forced 0 while reset is high)
//   mem_write, reg_write
//   adr_src, result_src,       datapath selects
//   alu_src_a, alu_src_b,
//   alu_op, imm_src
//   instr_retired              1-cycle pulse on the last cycle of an instruction
//   illegal                    unknown opcode seen (held while halted)
module multicycle_controller
  import mc_pkg::*;
#(
  parameter logic ILLEGAL_HALT = 1'b1,
  parameter int   STATE_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic       instr_retired,
  output logic       illegal
);

  logic [STATE_W-1:0] state_reg;
  logic [STATE_W-1:0] state_next;
  logic               pc_update;
  logic               branch;

  mc_imm_decode u_imm_decode (
    .op      (op),
    .imm_src (imm_src)
  );

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_FETCH;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    pc_update     = 1'b0;
    branch        = 1'b0;
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALU_ADD;
    reg_write     = 1'b0;
    instr_retired = 1'b0;
    illegal       = 1'b0;

    case (state_reg)
      S_FETCH: begin
        // PC+4 is computed and latched in the same cycle the fetch completes
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_update  = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        // ALU precomputes OldPC + imm as the beq/jal target
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECUTER;
          OP_I:         state_next = S_EXECUTEI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default: begin
            if (ILLEGAL_HALT) begin
              state_next = S_HALT;
            end else begin
              // unknown opcode retires here as a NOP
              state_next    = S_FETCH;
              instr_retired = 1'b1;
              illegal       = 1'b1;
            end
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src    = RES_DATA;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        state_next    = S_FETCH;
      end
      S_MEMWRITE: begin
        // strobe held for every wait cycle; retire only when the write lands
        adr_src       = 1'b1;
        mem_write     = 1'b1;
        instr_retired = mem_ready;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALU_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        state_next    = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a     = SRCA_RS1;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALU_SUB;
        branch        = 1'b1;
        instr_retired = 1'b1;
        state_next    = S_FETCH;
      end
      S_JAL: begin
        // ALUOut holds the DECODE target; ALU forms OldPC+4 for the link
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_update  = 1'b1;
        state_next = S_ALUWB;
      end
      S_HALT: begin
        illegal    = 1'b1;
        state_next = S_HALT;
      end
      default: state_next = S_FETCH;
    endcase

    pc_write = pc_update | (branch & zero);

    // reset aborts the current state: no enables, selects as in FETCH
    if (reset) begin
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      instr_retired = 1'b0;
      illegal       = 1'b0;
      adr_src       = 1'b0;
      result_src    = RES_ALU;
      alu_src_a     = SRCA_PC;
      alu_src_b     = SRCB_FOUR;
      alu_op        = ALU_ADD;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed cycle tables for the halting
// (ILLEGAL_HALT=1) and NOP (ILLEGAL_HALT=0) variants, then randomised
// instruction streams checked against an instruction-script reference model.
module tb_multicycle_controller;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RR  = 7'b0110011;
  localparam logic [6:0] II  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] ILL = 7'b1111111;

  // {pc_write,adr_src,mem_write,ir_write, result_src, alu_src_a, alu_src_b, alu_op,
  //  reg_write,instr_retired,illegal}
  localparam logic [15:0] V_RST  = {4'b0000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000};
  localparam logic [15:0] V_F0   = {4'b0000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000};
  localparam logic [15:0] V_F1   = {4'b1001, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000};
  localparam logic [15:0] V_DEC  = {4'b0000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000};
  localparam logic [15:0] V_DECX = {4'b0000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b011};
  localparam logic [15:0] V_MADR = {4'b0000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000};
  localparam logic [15:0] V_MRD  = {4'b0100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [15:0] V_MWB  = {4'b0000, 2'b01, 2'b00, 2'b00, 2'b00, 3'b110};
  localparam logic [15:0] V_MWR0 = {4'b0110, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [15:0] V_MWR1 = {4'b0110, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010};
  localparam logic [15:0] V_EXR  = {4'b0000, 2'b00, 2'b10, 2'b00, 2'b10, 3'b000};
  localparam logic [15:0] V_EXI  = {4'b0000, 2'b00, 2'b10, 2'b01, 2'b10, 3'b000};
  localparam logic [15:0] V_AWB  = {4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b110};
  localparam logic [15:0] V_BEQ1 = {4'b1000, 2'b00, 2'b10, 2'b00, 2'b01, 3'b010};
  localparam logic [15:0] V_BEQ0 = {4'b0000, 2'b00, 2'b10, 2'b00, 2'b01, 3'b010};
  localparam logic [15:0] V_JAL  = {4'b1000, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000};
  localparam logic [15:0] V_HALT = {4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001};

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        mr;
    logic        z;
    logic [15:0] exp;
  } vec_t;

  logic clk, reset, zero, mem_ready;
  logic [6:0] op;

  logic pc_write0, adr_src0, mem_write0, ir_write0, reg_write0, instr_retired0, illegal0;
  logic [1:0] result_src0, alu_src_a0, alu_src_b0, alu_op0, imm_src0;
  logic pc_write1, adr_src1, mem_write1, ir_write1, reg_write1, instr_retired1, illegal1;
  logic [1:0] result_src1, alu_src_a1, alu_src_b1, alu_op1, imm_src1;
  logic [15:0] o0, o1;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl0[$];
  vec_t tbl1[$];

  assign o0 = {pc_write0, adr_src0, mem_write0, ir_write0, result_src0, alu_src_a0,
               alu_src_b0, alu_op0, reg_write0, instr_retired0, illegal0};
  assign o1 = {pc_write1, adr_src1, mem_write1, ir_write1, result_src1, alu_src_a1,
               alu_src_b1, alu_op1, reg_write1, instr_retired1, illegal1};

  multicycle_controller #(.ILLEGAL_HALT(1'b1), .STATE_W(4)) dut_halt (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write0), .adr_src(adr_src0), .mem_write(mem_write0), .ir_write(ir_write0),
    .result_src(result_src0), .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0),
    .alu_op(alu_op0), .imm_src(imm_src0), .reg_write(reg_write0),
    .instr_retired(instr_retired0), .illegal(illegal0)
  );

  multicycle_controller #(.ILLEGAL_HALT(1'b0), .STATE_W(4)) dut_nop (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write1), .adr_src(adr_src1), .mem_write(mem_write1), .ir_write(ir_write1),
    .result_src(result_src1), .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1),
    .alu_op(alu_op1), .imm_src(imm_src1), .reg_write(reg_write1),
    .instr_retired(instr_retired1), .illegal(illegal1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == SW) return 2'b01;
    if (o == BQ) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic bit is_legal(input logic [6:0] o);
    return (o == LW) || (o == SW) || (o == RR) || (o == II) || (o == BQ) || (o == JL);
  endfunction

  // Instruction length in cycles when memory never stalls
  function automatic int n_steps(input logic [6:0] o);
    if (o == LW) return 5;
    if (o == BQ) return 3;
    if (!is_legal(o)) return 2;
    return 4;
  endfunction

  // Steps that hold until the memory port completes: the fetch and the lw/sw access
  function automatic bit waits_mem(input logic [6:0] o, input int s);
    return (s == 0) || (s == 3 && (o == LW || o == SW));
  endfunction

  // Expected outputs for step s of an instruction with opcode o (non-halting variant)
  function automatic logic [15:0] model_vec(input logic [6:0] o, input int s,
                                            input logic m, input logic z);
    if (s == 0) return m ? V_F1 : V_F0;
    if (s == 1) return is_legal(o) ? V_DEC : V_DECX;
    case (o)
      LW:      return (s == 2) ? V_MADR : (s == 3) ? V_MRD : V_MWB;
      SW:      return (s == 2) ? V_MADR : (m ? V_MWR1 : V_MWR0);
      RR:      return (s == 2) ? V_EXR : V_AWB;
      II:      return (s == 2) ? V_EXI : V_AWB;
      BQ:      return z ? V_BEQ1 : V_BEQ0;
      JL:      return (s == 2) ? V_JAL : V_AWB;
      default: return V_HALT;
    endcase
  endfunction

  task automatic check(input string tag, input int idx, input logic [17:0] got,
                       input logic [17:0] want, input bit verbose);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s[%0d] got=%b want=%b", tag, idx, got, want);
    end else if (verbose) begin
      $display("ok   %s[%0d] outputs=%b", tag, idx, got);
    end
  endtask

  task automatic add0(input logic r, input logic [6:0] o, input logic m, input logic z,
                      input logic [15:0] e);
    vec_t v;
    v.rst = r; v.op = o; v.mr = m; v.z = z; v.exp = e;
    tbl0.push_back(v);
  endtask

  task automatic add1(input logic r, input logic [6:0] o, input logic m, input logic z,
                      input logic [15:0] e);
    vec_t v;
    v.rst = r; v.op = o; v.mr = m; v.z = z; v.exp = e;
    tbl1.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; op = v.op; mem_ready = v.mr; zero = v.z;
    @(negedge clk);
  endtask

  initial begin
    int step;
    logic [6:0] cur;
    reset = 1'b1; op = LW; mem_ready = 1'b0; zero = 1'b0;

    // ---- ILLEGAL_HALT=1 directed table ----
    repeat (3) add0(1, LW, 1, 1, V_RST);                       // enables held off in reset
    add0(0, LW, 1, 0, V_F1);  add0(0, LW, 1, 1, V_DEC);  add0(0, LW, 1, 1, V_MADR);
    add0(0, LW, 1, 1, V_MRD); add0(0, LW, 1, 1, V_MWB);
    add0(0, LW, 0, 0, V_F0);  add0(0, LW, 1, 0, V_F1);   add0(0, LW, 1, 0, V_DEC);
    add0(0, LW, 1, 0, V_MADR); add0(0, LW, 0, 0, V_MRD); add0(0, LW, 1, 0, V_MRD);
    add0(0, LW, 1, 0, V_MWB);
    add0(0, SW, 1, 0, V_F1);  add0(0, SW, 1, 0, V_DEC);  add0(0, SW, 1, 0, V_MADR);
    add0(0, SW, 0, 0, V_MWR0); add0(0, SW, 0, 1, V_MWR0); add0(0, SW, 1, 0, V_MWR1);
    add0(0, BQ, 1, 1, V_F1);  add0(0, BQ, 1, 1, V_DEC);  add0(0, BQ, 1, 1, V_BEQ1);
    add0(0, BQ, 1, 0, V_F1);  add0(0, BQ, 1, 0, V_DEC);  add0(0, BQ, 1, 0, V_BEQ0);
    add0(0, JL, 1, 0, V_F1);  add0(0, JL, 1, 0, V_DEC);  add0(0, JL, 1, 0, V_JAL);
    add0(0, JL, 1, 1, V_AWB);
    add0(0, RR, 1, 0, V_F1);  add0(0, RR, 1, 0, V_DEC);  add0(0, RR, 1, 0, V_EXR);
    add0(0, RR, 1, 0, V_AWB);
    add0(0, II, 1, 0, V_F1);  add0(0, II, 1, 0, V_DEC);  add0(0, II, 1, 0, V_EXI);
    add0(0, II, 1, 0, V_AWB);
    // reset lands on the ALUWB cycle: no write, restart at FETCH
    add0(0, RR, 1, 0, V_F1);  add0(0, RR, 1, 0, V_DEC);  add0(0, RR, 1, 0, V_EXR);
    add0(1, RR, 1, 1, V_RST); add0(0, LW, 1, 0, V_F1);   add0(0, LW, 1, 0, V_DEC);
    // reset during a MEMWRITE stall drops the strobe at once
    add0(0, SW, 1, 0, V_MADR); add0(0, SW, 0, 0, V_MWR0); add0(1, SW, 0, 0, V_RST);
    // unknown opcode halts until reset
    add0(0, ILL, 1, 1, V_F1); add0(0, ILL, 1, 1, V_DEC); add0(0, ILL, 1, 1, V_HALT);
    add0(0, LW, 1, 1, V_HALT); add0(0, BQ, 1, 1, V_HALT);
    add0(1, ILL, 1, 1, V_RST); add0(0, RR, 1, 0, V_F1);  add0(0, RR, 1, 0, V_DEC);
    add0(0, RR, 1, 0, V_EXR);  add0(0, RR, 1, 0, V_AWB);

    // ---- ILLEGAL_HALT=0 hand sequence: unknown opcode retires in DECODE ----
    add1(1, ILL, 1, 0, V_RST); add1(0, ILL, 1, 0, V_F1); add1(0, ILL, 1, 0, V_DECX);
    add1(0, 7'h00, 1, 0, V_F1); add1(0, 7'h00, 1, 1, V_DECX);
    add1(0, II, 1, 0, V_F1);  add1(0, II, 1, 0, V_DEC);  add1(0, II, 1, 0, V_EXI);
    add1(0, II, 1, 0, V_AWB);

    for (int i = 0; i < tbl0.size(); i++) begin
      drive(tbl0[i]);
      check("halt_tbl", i, {o0, imm_src0}, {tbl0[i].exp, imm_of(tbl0[i].op)}, 1'b1);
      @(posedge clk); #1;
    end

    for (int i = 0; i < tbl1.size(); i++) begin
      drive(tbl1[i]);
      check("nop_seq", i, {o1, imm_src1}, {tbl1[i].exp, imm_of(tbl1[i].op)}, 1'b1);
      @(posedge clk); #1;
    end

    // ---- randomised instruction stream on the non-halting variant ----
    reset = 1'b1; mem_ready = 1'b1; op = LW; zero = 1'b0;
    @(negedge clk);
    check("rnd_reset", 0, {o1, imm_src1}, {V_RST, imm_of(LW)}, 1'b1);
    @(posedge clk); #1;
    step = 0;
    cur = LW;
    for (int c = 0; c < 1500; c++) begin
      logic r, m, z;
      logic [15:0] e;
      int pick;
      if (step == 0) begin
        pick = $urandom_range(0, 7);
        case (pick)
          0: cur = LW;  1: cur = SW;  2: cur = RR;  3: cur = II;
          4: cur = BQ;  5: cur = JL;  6: cur = ILL;
          default: cur = 7'($urandom_range(0, 127));
        endcase
      end
      r = ($urandom_range(0, 39) == 0);
      m = ($urandom_range(0, 3) != 0);
      z = 1'($urandom_range(0, 1));
      reset = r; op = cur; mem_ready = m; zero = z;
      @(negedge clk);
      e = r ? V_RST : model_vec(cur, step, m, z);
      check("rnd", c, {o1, imm_src1}, {e, imm_of(cur)}, 1'b0);
      if (r) begin
        step = 0;
        $display("rnd cycle %0d: reset, op=%b aborted", c, cur);
      end else if (!waits_mem(cur, step) || m) begin
        step++;
        if (step == n_steps(cur)) begin
          step = 0;
          $display("rnd cycle %0d: op=%b completed", c, cur);
        end
      end
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
